// File: rtl/debug_send_pkg.sv
// ============================================================================
// Module      : debug_send_pkg
// Description : Shared types and constants for the debug send arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_send_pkg;

    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    // The source tag occupies the top TAG_W bits of the outgoing word.
    localparam int TAG_W = ID_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin picker; the first pending index
//               after 'last' wins, so 'last' itself has the lowest priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
    import debug_send_pkg::*;
(
    input  logic [NREQ-1:0] pending,
    input  logic [ID_W-1:0] last,
    output logic            any,
    output logic [ID_W-1:0] idx
);

    logic [ID_W-1:0] w_cand;

    // Scan from the far end back toward last+1 so the nearest hit is kept.
    always_comb begin
        any    = |pending;
        idx    = last + ID_W'(1);
        w_cand = last;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = last + ID_W'(k);
            if (pending[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_send_arbiter.sv
// ============================================================================
// Module      : debug_send_arbiter
// Description : Round-robin share of one serial debug sender among four
//               requesters, each with a one-deep holding register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_send_arbiter
    import debug_send_pkg::*;
#(
    parameter int DW          = 40,
    parameter bit TAG_EN      = 1'b1,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      drop_sticky,
    input  logic                 drop_clr,
    output logic                 snd_valid,
    output logic [DW-1:0]        snd_data,
    input  logic                 snd_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    localparam logic [7:0] c_ack_last = 8'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] drop_q, drop_d;
    logic [DW-1:0]   hold_q [NREQ];
    logic [DW-1:0]   snd_data_q, snd_data_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;

    logic            w_any;
    logic [ID_W-1:0] w_idx;
    logic [DW-1:0]   w_word;
    logic            w_accept;
    logic [NREQ-1:0] w_capture;
    logic [NREQ-1:0] w_clear;

    rr_pick4 u_pick (
        .pending (pending_q),
        .last    (last_q),
        .any     (w_any),
        .idx     (w_idx)
    );

    // Capture decisions use the pre-edge pending, so a word arriving in the
    // acceptance cycle sees pending still set and is dropped.
    assign w_capture = req_valid & ~pending_q;
    assign w_clear   = w_accept ? (NREQ'(1) << grant_q) : '0;
    assign pending_d = (pending_q | w_capture) & ~w_clear;
    assign drop_d    = (drop_clr ? '0 : drop_q) | (req_valid & pending_q);

    for (genvar i = 0; i < NREQ; i++) begin : g_hold
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q[i] <= '0;
            end else if (w_capture[i]) begin
                hold_q[i] <= req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_word = hold_q[w_idx];
        if (TAG_EN) begin
            w_word[DW-1 -: TAG_W] = w_idx;
        end
    end

    always_comb begin
        state_d       = state_q;
        snd_data_d    = snd_data_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        w_accept      = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any && !snd_busy) begin
                    snd_data_d = w_word;
                    grant_d    = w_idx;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (snd_busy) begin
                    w_accept = 1'b1;
                    last_d   = grant_q;
                    state_d  = WAIT_DONE;
                end else if (cnt_q == c_ack_last) begin
                    // Word stays pending and competes again after the others.
                    timeout_pulse = 1'b1;
                    last_d        = grant_q;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!snd_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            drop_q     <= '0;
            snd_data_q <= '0;
            grant_q    <= '0;
            last_q     <= ID_W'(NREQ - 1);
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            snd_data_q <= snd_data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ready   = ~pending_q;
    assign drop_sticky = drop_q;
    assign snd_valid   = (state_q == ISSUE);
    assign snd_data    = snd_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_debug_send_arbiter.sv
// ============================================================================
// Module      : tb_debug_send_arbiter
// Description : Directed and randomized bench for debug_send_arbiter with a
//               transaction-level reference model and a simple sender model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_send_arbiter;

    localparam int DW = 40;
    localparam int TO = 4;

    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_ACK   = 2;
    localparam int M_DRAIN = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_ready;
    logic [3:0]      drop_sticky;
    logic            drop_clr;
    logic            snd_valid;
    logic [DW-1:0]   snd_data;
    logic            snd_busy;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout_pulse;

    always #5 clk = ~clk;

    debug_send_arbiter #(
        .DW          (DW),
        .TAG_EN      (1'b1),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .drop_sticky   (drop_sticky),
        .drop_clr      (drop_clr),
        .snd_valid     (snd_valid),
        .snd_data      (snd_data),
        .snd_busy      (snd_busy),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: which words are waiting, which one is on the wire,
    // and how many cycles have passed since it was offered.
    bit [3:0]      m_pend;
    bit [3:0]      m_drop;
    logic [DW-1:0] m_hold [4];
    logic [DW-1:0] m_data;
    int            m_last, m_stage, m_g, m_age;

    // Sender model state and knobs.
    int s_ack_in, s_hold, s_dur, s_noack;
    int force_delay = 2;
    int force_dur   = 2;
    bit glitch_en   = 1'b0;

    logic [DW-1:0] d_word [4];
    int            q_gr[$];
    int            n_to;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_drop = '0; m_data = '0;
        m_last = 3; m_stage = M_IDLE; m_g = 0; m_age = 0;
        for (int i = 0; i < 4; i++) m_hold[i] = '0;
        s_ack_in = 0; s_hold = 0; s_dur = 1; s_noack = 0;
    endtask

    task automatic compare();
        bit [3:0] e_ready;
        bit       e_to;
        e_ready = ~m_pend;
        e_to    = (m_stage == M_ACK) && !snd_busy && (m_age == TO);
        chk("req_ready", req_ready, e_ready);
        chk("drop_sticky", drop_sticky, m_drop);
        chk("snd_valid", snd_valid, m_stage == M_ISSUE);
        chk("busy", busy, m_stage != M_IDLE);
        chk("timeout_pulse", timeout_pulse, e_to);
        chk("grant_id", grant_id, m_g);
        chk("snd_data", snd_data, m_data);
        if (snd_valid === 1'b1) q_gr.push_back(int'(grant_id));
        if (timeout_pulse === 1'b1) n_to++;
    endtask

    task automatic model_step();
        bit [3:0] np;
        bit       found;
        np = m_pend;
        m_drop = drop_clr ? 4'b0 : m_drop;
        case (m_stage)
            M_IDLE: begin
                if (m_pend != 4'b0 && !snd_busy) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        if (!found && m_pend[(m_last + k) % 4]) begin
                            m_g   = (m_last + k) % 4;
                            found = 1'b1;
                        end
                    end
                    m_data = m_hold[m_g];
                    m_data[DW-1 -: 2] = m_g[1:0];
                    m_stage = M_ISSUE;
                end
            end
            M_ISSUE: begin
                m_stage = M_ACK;
                m_age   = 1;
            end
            M_ACK: begin
                if (snd_busy) begin
                    np[m_g] = 1'b0;
                    m_last  = m_g;
                    m_stage = M_DRAIN;
                end else if (m_age == TO) begin
                    m_last  = m_g;
                    m_stage = M_IDLE;
                end else begin
                    m_age++;
                end
            end
            default: if (!snd_busy) m_stage = M_IDLE;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i]) begin
                if (m_pend[i]) begin
                    m_drop[i] = 1'b1;
                end else begin
                    np[i]     = 1'b1;
                    m_hold[i] = req_data[i*DW +: DW];
                end
            end
        end
        m_pend = np;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic cyc(input bit [3:0] v, input bit clr);
        if (m_stage == M_ISSUE) begin
            if (s_noack > 0) begin
                s_noack--;
                s_ack_in = -1;
            end else if (force_delay > 0) begin
                s_ack_in = force_delay;
            end else begin
                s_ack_in = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 6));
            end
            s_dur = (force_dur > 0) ? force_dur : int'($urandom_range(1, 4));
        end else if (s_ack_in > 0) begin
            s_ack_in--;
            if (s_ack_in == 0) s_hold = s_dur;
        end
        if (glitch_en && m_stage == M_IDLE && s_hold == 0 && s_ack_in <= 0
            && $urandom_range(0, 9) == 0) s_hold = 1;
        snd_busy = (s_hold > 0);
        if (s_hold > 0) s_hold--;
        req_valid = v;
        drop_clr  = clr;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = d_word[i];
        #1;
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; drop_clr = 1'b0; snd_busy = 1'b0; req_data = '0;
        #1;
        chk("rst_ready", req_ready, 4'hF);
        chk("rst_drop", drop_sticky, 4'h0);
        chk("rst_valid", snd_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_pulse, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_data", snd_data, '0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(busy === 1'b0 && req_ready === 4'hF) && n < limit) begin
            cyc(4'b0, 1'b0);
            n++;
        end
        chk("wait_idle", {busy, req_ready}, 5'b0_1111);
    endtask

    task automatic wait_issue(input int limit);
        int n = 0;
        while (snd_valid !== 1'b1 && n < limit) begin
            cyc(4'b0, 1'b0);
            n++;
        end
        chk("wait_issue", snd_valid, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] e_w;
        bit [3:0]      v;
        int            n;
        for (int i = 0; i < 4; i++) d_word[i] = '0;
        model_reset();
        do_reset();

        // Single request: latency, tag and acceptance.
        d_word[0] = 40'hA9_9999_9991;
        cyc(4'b0001, 1'b0);
        cyc(4'b0000, 1'b0);
        chk("t1_valid", snd_valid, 1'b1);
        chk("t1_data", snd_data, 40'h29_9999_9991);
        force_dur = 3;
        repeat (40) cyc(4'b0000, 1'b0);
        chk("t1_ready", req_ready, 4'hF);

        // All four at once from reset priority, then 3 and 0 together.
        do_reset();
        force_dur = 2;
        for (int i = 0; i < 4; i++) d_word[i] = {8'($urandom), $urandom};
        q_gr.delete();
        cyc(4'b1111, 1'b0);
        wait_idle(200);
        chk("t2_count", q_gr.size(), 4);
        for (int i = 0; i < 4 && i < q_gr.size(); i++) chk("t2_order", q_gr[i], i);
        q_gr.delete();
        cyc(4'b1001, 1'b0);
        wait_idle(200);
        chk("t2b_count", q_gr.size(), 2);
        if (q_gr.size() == 2) begin
            chk("t2b_first", q_gr[0], 0);
            chk("t2b_second", q_gr[1], 3);
        end

        // Overflow on requester 2, then drop_clr colliding with a new drop.
        d_word[2] = 40'h12_3456_789A;
        cyc(4'b0100, 1'b0);
        d_word[2] = 40'hFF_FFFF_FFFF;
        cyc(4'b0100, 1'b0);
        chk("t3_drop", drop_sticky, 4'b0100);
        e_w = 40'h92_3456_789A;
        chk("t3_word", snd_data, e_w);
        cyc(4'b0100, 1'b1);
        chk("t3_clr_set", drop_sticky, 4'b0100);
        cyc(4'b0000, 1'b1);
        chk("t3_clr", drop_sticky, 4'b0000);
        wait_idle(200);

        // Acknowledge timeout: retry after the other pending requester.
        q_gr.delete();
        n_to = 0;
        s_noack = 1;
        cyc(4'b0011, 1'b0);
        wait_idle(200);
        chk("t4_timeouts", n_to, 1);
        chk("t4_count", q_gr.size(), 3);
        if (q_gr.size() == 3) begin
            chk("t4_g0", q_gr[0], 0);
            chk("t4_g1", q_gr[1], 1);
            chk("t4_g2", q_gr[2], 0);
        end

        // Asynchronous reset while the sender drains requester 1's word.
        force_dur = 6;
        cyc(4'b0010, 1'b0);
        n = 0;
        while (m_stage != M_DRAIN && n < 50) begin
            cyc(4'b0000, 1'b0);
            n++;
        end
        chk("t5_in_drain", busy, 1'b1);
        do_reset();
        force_dur = 2;
        q_gr.delete();
        cyc(4'b1001, 1'b0);
        wait_idle(200);
        chk("t5_count", q_gr.size(), 2);
        if (q_gr.size() == 2) chk("t5_first", q_gr[0], 0);

        // New word on requester 1 in the cycle its word is accepted.
        cyc(4'b0010, 1'b0);
        wait_issue(50);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);
        cyc(4'b0010, 1'b0);
        chk("t6_drop", drop_sticky[1], 1'b1);
        wait_idle(200);

        // Randomized traffic with a misbehaving sender.
        force_delay = 0;
        force_dur   = 0;
        glitch_en   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                d_word[i] = {8'($urandom), $urandom};
                v[i] = ($urandom_range(0, 3) == 0);
            end
            cyc(v, $urandom_range(0, 15) == 0);
        end
        glitch_en   = 1'b0;
        force_delay = 2;
        force_dur   = 2;
        wait_idle(400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debug_send_arbiter.md
Name: debug_send_arbiter

Overview:
- Shares the single serial debug data sender among four debug-word requesters on the sender's input-side clock.
- Each requester has a one-deep holding register; pending words are granted round-robin.
- The winning word is presented to the sender as a one-cycle valid pulse.
- The block waits for the sender to accept the word and drain it before the next grant, and optionally tags the word with its source ID.

Parameters:
- DW, 40: debug word width; must match the sender word width.
- TAG_EN, 1: when 1, snd_data[DW-1:DW-2] is overwritten with the granted requester ID.
- ACK_TIMEOUT, 255: cycles to wait in WAIT_ACK for snd_busy to rise; range 1..255 (8-bit counter).

Ports:
- clk  in  1  Sender input-side clock; the block's only clock.
- rst_n  in  1  Reset, asynchronous assert, active-low.
- req_valid  in  4  One-cycle pulse per requester; presents a word.
- req_data  in  4*DW  Words, flattened; requester i uses bits [i*DW +: DW].
- req_ready  out  4  req_ready[i] = ~pending[i] (combinational from flop).
- drop_sticky  out  4  Sticky flag per requester: a word arrived while pending.
- drop_clr  in  1  Clears all drop_sticky bits.
- snd_valid  out  1  One-cycle pulse to the sender's data_valid input.
- snd_data  out  DW  Registered word to the sender; held stable until the next grant.
- snd_busy  in  1  Sender cannot accept: its captured-word flag ORed with its awaiting-drain flag; synchronous to clk.
- grant_id  out  2  ID of the last issued requester.
- busy  out  1  High when state is not IDLE.
- timeout_pulse  out  1  One cycle high on an acknowledge timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pending, drop_sticky, snd_valid and timeout_pulse all 0.
  - snd_data=0, grant_id=0, busy=0, counter=0.
  - last_grant=3, so requester 0 has first priority.
  - Reset mid-transfer abandons the word; the sender is not notified.
- Capture, per requester i, every cycle:
  - If req_valid[i] && !pending[i]: hold[i]<=word and pending[i]<=1.
  - If req_valid[i] && pending[i]: word discarded and drop_sticky[i]<=1.
  - Capture uses the pre-edge pending. A valid in the same cycle that pending clears (acceptance) is therefore dropped.
  - A drop and drop_clr in the same cycle: the set wins.
- State machine with states IDLE, ISSUE, WAIT_ACK and WAIT_DONE:
  - IDLE:
    - If |pending && !snd_busy, pick g = first pending index scanning last_grant+1, +2, +3, +4, all mod 4.
    - Load snd_data<=hold[g], with bits [DW-1:DW-2]=g if TAG_EN. Set grant_id<=g and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: snd_valid=1 for exactly this cycle; counter<=0; go to WAIT_ACK.
  - WAIT_ACK:
    - If snd_busy=1: pending[g]<=0, last_grant<=g, go to WAIT_DONE.
    - Else if counter==ACK_TIMEOUT-1: timeout_pulse=1, last_grant<=g, pending[g] kept (retried later), go to IDLE.
    - Else counter<=counter+1.
  - WAIT_DONE: when snd_busy=0 go to IDLE; no timeout.
- Latency:
  - With the block IDLE and the sender free, req_valid at cycle 0 gives pending at cycle 1 and snd_valid at cycle 2.
  - From sender drain (snd_busy falling) to the next snd_valid: 2 cycles.
- Fairness: after any grant or timeout for g, requester g has lowest priority in the next scan.
- Only one word is in flight; snd_valid is never asserted outside ISSUE.

Decomposition:
- Package debug_send_pkg holds:
  - State encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3.
  - NREQ=4, ID_W=2, and the tag bit positions.
- One sub-module, rr_pick4: combinational; inputs pending[3:0] and last[1:0]; outputs any and idx[1:0].

Test Plan:
1. Reset, then req_valid[0] with 40'hA9_9999_9991 and snd_busy modelled 2 cycles after the valid pulse, for 40 cycles -> snd_valid at cycle 2, snd_data=40'h29_9999_9991 (tag 00), pending[0] clears on acceptance, busy low 1 cycle after snd_busy falls.
2. All four requesters pulse in the same cycle -> grants in order 0,1,2,3 with tags 00,01,10,11. Then pulse requesters 3 and 0 together -> grant order 0, then 3.
3. req_valid[2] twice in a row while pending[2]=1 -> second word dropped, drop_sticky=4'b0100, first word sent unchanged. Then drop_clr together with a new drop on requester 2 -> drop_sticky stays 4'b0100.
4. snd_busy held 0 after ISSUE, ACK_TIMEOUT=4 -> timeout_pulse 4 cycles after snd_valid, pending kept, next grant goes to another pending requester first, then the same word is reissued.
5. Deassert rst_n during WAIT_DONE -> all outputs return to reset values immediately (async), pending=0, and the next request is served from requester 0 priority.
6. req_valid[1] in the same cycle that snd_busy rises for requester 1 -> new word dropped and drop_sticky[1]=1.
